// File: rtl/obi_rr_arbiter_if.sv
// Bundle of the OBI signals around the N-to-1 arbiter.
// m_* is the bank of master-side ports, s_* is the single shared slave port.
interface obi_rr_arbiter_if #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) ();

   logic [NUM_MASTERS-1:0]                m_req;
   logic [NUM_MASTERS-1:0][ADDR_W-1:0]    m_addr;
   logic [NUM_MASTERS-1:0]                m_we;
   logic [NUM_MASTERS-1:0][DATA_W/8-1:0]  m_be;
   logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_wdata;
   logic [NUM_MASTERS-1:0]                m_gnt;
   logic [NUM_MASTERS-1:0]                m_rvalid;
   logic [NUM_MASTERS-1:0][DATA_W-1:0]    m_rdata;

   logic                                  s_req;
   logic [ADDR_W-1:0]                     s_addr;
   logic                                  s_we;
   logic [DATA_W/8-1:0]                   s_be;
   logic [DATA_W-1:0]                     s_wdata;
   logic                                  s_gnt;
   logic                                  s_rvalid;
   logic [DATA_W-1:0]                     s_rdata;

   // Requesting masters: drive address phase, receive gnt/response.
   modport master (
      output m_req, m_addr, m_we, m_be, m_wdata,
      input  m_gnt, m_rvalid, m_rdata
   );

   // Shared slave: receives the arbitrated request, returns gnt/response.
   modport slave (
      input  s_req, s_addr, s_we, s_be, s_wdata,
      output s_gnt, s_rvalid, s_rdata
   );

   // Arbiter view: sits between the masters and the shared slave.
   modport arb (
      input  m_req, m_addr, m_we, m_be, m_wdata,
      output m_gnt, m_rvalid, m_rdata,
      output s_req, s_addr, s_we, s_be, s_wdata,
      input  s_gnt, s_rvalid, s_rdata
   );

endinterface

// File: rtl/obi_rr_arbiter.sv
// Round-robin N-to-1 OBI arbiter with address-phase lock and an index FIFO
// that steers in-order responses back to the master that was granted.
module obi_rr_arbiter #(
   parameter int NUM_MASTERS     = 3,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ADDR_W          = 32,
   parameter int DATA_W          = 32,
   localparam int IDX_W = $clog2(NUM_MASTERS),
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1),
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   obi_rr_arbiter_if.arb      bus,
   output logic [CNT_W-1:0]   outstanding_o,
   output logic               err_unexpected_rvalid_o
);

   logic [IDX_W-1:0]                       rr_ptr_q, rr_ptr_d;
   logic                                   lock_valid_q, lock_valid_d;
   logic [IDX_W-1:0]                       lock_idx_q, lock_idx_d;
   logic [MAX_OUTSTANDING-1:0][IDX_W-1:0]  fifo_q, fifo_d;
   logic [PTR_W-1:0]                       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]                       rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]                       count_q, count_d;
   logic                                   err_q, err_d;

   logic [IDX_W:0]   cand;
   logic             found;
   logic [IDX_W-1:0] pick;
   logic [IDX_W-1:0] sel;
   logic [IDX_W-1:0] head;
   logic             full;
   logic             pop;
   logic             push;
   logic             req_out;

   // Pick the first requester at or after rr_ptr; a pending lock overrides.
   always_comb begin
      found = 1'b0;
      pick  = rr_ptr_q;
      cand  = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
         if (cand >= (IDX_W+1)'(NUM_MASTERS)) cand = cand - (IDX_W+1)'(NUM_MASTERS);
         if (!found && bus.m_req[cand[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = cand[IDX_W-1:0];
         end
      end
      sel = lock_valid_q ? lock_idx_q : pick;
   end

   // Handshake qualifiers; a pop at full frees a slot for a same-cycle push.
   always_comb begin
      head    = fifo_q[rd_ptr_q];
      full    = (count_q == CNT_W'(MAX_OUTSTANDING));
      pop     = rst_ni & bus.s_rvalid & (count_q != '0);
      req_out = rst_ni & bus.m_req[sel] & ~(full & ~pop);
      push    = req_out & bus.s_gnt;
   end

   // Forward the selected address phase and route gnt / response.
   always_comb begin
      bus.s_req    = req_out;
      bus.s_addr   = req_out ? bus.m_addr[sel]  : '0;
      bus.s_we     = req_out ? bus.m_we[sel]    : 1'b0;
      bus.s_be     = req_out ? bus.m_be[sel]    : '0;
      bus.s_wdata  = req_out ? bus.m_wdata[sel] : '0;
      bus.m_gnt    = '0;
      bus.m_rvalid = '0;
      bus.m_rdata  = '0;
      if (push) bus.m_gnt[sel] = 1'b1;
      if (pop) begin
         bus.m_rvalid[head] = 1'b1;
         bus.m_rdata[head]  = bus.s_rdata;
      end
   end

   // Next-state: FIFO push/pop, round-robin advance, lock capture, error flag.
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      lock_valid_d = lock_valid_q;
      lock_idx_d   = lock_idx_q;
      fifo_d       = fifo_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = sel;
         wr_ptr_d     = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : wr_ptr_q + PTR_W'(1);
         rr_ptr_d     = (sel == IDX_W'(NUM_MASTERS-1)) ? '0 : sel + IDX_W'(1);
         lock_valid_d = 1'b0;
      end else if (req_out) begin
         lock_valid_d = 1'b1;
         lock_idx_d   = sel;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING-1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      err_d   = err_q | (rst_ni & bus.s_rvalid & (count_q == '0));
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_ptr_q     <= '0;
         lock_valid_q <= 1'b0;
         lock_idx_q   <= '0;
         fifo_q       <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         err_q        <= 1'b0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         lock_valid_q <= lock_valid_d;
         lock_idx_q   <= lock_idx_d;
         fifo_q       <= fifo_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         err_q        <= err_d;
      end
   end

   assign outstanding_o           = count_q;
   assign err_unexpected_rvalid_o = err_q;

endmodule
